if_stage: RTL and testbench
===========================

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0013, value driven on instr_o when no instruction is valid.
REQ-003 clk_i  input  1  single clock, all state updates on rising edge.
REQ-004 rst_i  input  1  reset, asynchronous, active-high.
REQ-005 br_taken_i  input  1  redirect request from execute stage.
REQ-006 new_pc_i  input  32  redirect target, sampled when br_taken_i=1.
REQ-007 stall_i  input  1  decode not ready; holds the head instruction.
REQ-008 imem_req_o  output  1  instruction memory request valid.
REQ-009 imem_addr_o  output  32  word-aligned fetch address.
REQ-010 imem_ready_i  input  1  memory accepts request when imem_req_o=1 and imem_ready_i=1.
REQ-011 imem_rvalid_i  input  1  read data valid, at least one cycle after acceptance.
REQ-012 imem_rdata_i  input  32  instruction word.
REQ-013 instr_valid_o  output  1  head buffer entry valid.
REQ-014 instr_o  output  32  head instruction, NOP_INSTR when instr_valid_o=0.
REQ-015 pc_o  output  32  PC of head instruction, 0 when instr_valid_o=0.
REQ-016 pc_plus4_o  output  32  pc_o + 4, modulo 2^32.

Function
REQ-017 Block SHALL hold a fetch PC register, a 2-entry FIFO of {pc, instr}, and a 3-state FSM: FETCH, WAIT, DISCARD.
REQ-018 At most one memory request SHALL be outstanding (accepted, response not yet received).
REQ-019 FETCH: imem_req_o=1 iff FIFO count + outstanding < 2; imem_addr_o = fetch PC; on acceptance fetch PC += 4 (wraps at 2^32) and FSM -> WAIT.
REQ-020 imem_addr_o SHALL remain stable while imem_req_o=1 and not accepted, except on redirect.
REQ-021 WAIT: on imem_rvalid_i=1, {request address, imem_rdata_i} SHALL be pushed into FIFO; FSM -> FETCH; pushed entry is visible on outputs the next cycle (1-cycle latency rvalid -> instr_valid_o when FIFO was empty).
REQ-022 Pop SHALL occur when instr_valid_o=1 and stall_i=0; push and pop in the same cycle SHALL both take effect.
REQ-023 FIFO overflow SHALL be impossible by construction of REQ-019; FIFO order is strict FIFO.
REQ-024 Redirect (br_taken_i=1) SHALL flush the FIFO next cycle, set fetch PC to {new_pc_i[31:2], 2'b00}.
REQ-025 Redirect in FETCH or with request pending but not accepted: FSM stays/returns FETCH; imem_addr_o shows new target next cycle.
REQ-026 Redirect in WAIT without same-cycle imem_rvalid_i: FSM -> DISCARD; the response, when it arrives, SHALL be dropped; then FSM -> FETCH, no request issued in DISCARD.
REQ-027 Redirect with same-cycle imem_rvalid_i in WAIT: response dropped, FSM -> FETCH.
REQ-028 Redirect in the same cycle as request acceptance: accepted request SHALL be treated as stale, FSM -> DISCARD.
REQ-029 Redirect in DISCARD: fetch PC updated to new target, FSM remains DISCARD until pending response drops.
REQ-030 Redirect SHALL take priority over pop and push in the same cycle.

Reset
REQ-031 On rst_i=1: FSM=FETCH, fetch PC=RESET_PC, FIFO empty, outstanding cleared, imem_req_o=0, imem_addr_o=RESET_PC, instr_valid_o=0, instr_o=NOP_INSTR, pc_o=0, pc_plus4_o=4.
REQ-032 imem_req_o SHALL assert in the first cycle after rst_i deasserts.
REQ-033 Reset asserted mid-transaction SHALL abandon the outstanding response; responses arriving before first new request SHALL be ignored.

Verification
REQ-034 Reset release, imem_ready_i=1, rvalid one cycle after accept, rdata=32'h00500093 -> pc_o=0, instr_o=32'h00500093, then pc_o=4, 8 in order.
REQ-035 stall_i=1 held 10 cycles -> FIFO fills to 2, imem_req_o=0, instr_o/pc_o stable; release -> entries drain in order, no loss.
REQ-036 br_taken_i=1, new_pc_i=32'h0000_0103 while WAIT, rvalid 3 cycles later -> stale word dropped, next request address 32'h0000_0100, FIFO empty meanwhile.
REQ-037 br_taken_i and imem_rvalid_i same cycle -> rdata not delivered, next imem_addr_o = redirect target.
REQ-038 Fetch PC 32'hFFFF_FFFC accepted -> next address 32'h0000_0000; pc_plus4_o=0 for that entry.
REQ-039 rst_i asserted while request outstanding -> outputs at reset values immediately (asynchronous), first fetch RESET_PC after release.

Source files
------------

// File: rtl/if_stage.sv
// Instruction fetch stage: fetch PC, single-outstanding memory request FSM and a
// 2-entry {pc, instr} buffer feeding decode, with redirect flush and stale-response drop.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        br_taken_i,
  input  logic [31:0] new_pc_i,
  input  logic        stall_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ready_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o
);

  typedef enum logic [1:0] {FETCH, WAIT, DISCARD} state_t;

  state_t      state;
  logic [31:0] fetch_pc;
  logic [31:0] req_pc;
  logic [31:0] fifo_pc    [2];
  logic [31:0] fifo_instr [2];
  logic        rd_ptr, wr_ptr;
  logic [1:0]  count;

  logic        accept, push, pop;
  logic [31:0] target;
  logic        unused_low;

  assign target     = {new_pc_i[31:2], 2'b00};
  assign unused_low = ^new_pc_i[1:0];

  // In FETCH nothing is outstanding, so count < 2 is the whole credit check.
  // Gating with rst_i keeps the request low while reset is held.
  assign imem_req_o  = !rst_i && (state == FETCH) && (count != 2'd2);
  assign imem_addr_o = fetch_pc;
  assign accept      = imem_req_o && imem_ready_i;
  assign push        = (state == WAIT) && imem_rvalid_i && !br_taken_i;
  assign pop         = instr_valid_o && !stall_i && !br_taken_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= FETCH;
      fetch_pc <= RESET_PC;
      req_pc   <= RESET_PC;
    end else begin
      if (accept)
        req_pc <= fetch_pc;
      if (br_taken_i)
        fetch_pc <= target;
      else if (accept)
        fetch_pc <= fetch_pc + 32'd4;
      case (state)
        FETCH:   if (accept) state <= br_taken_i ? DISCARD : WAIT;
        WAIT: begin
          // A response landing with the redirect is dropped and closes the transaction.
          if (imem_rvalid_i)   state <= FETCH;
          else if (br_taken_i) state <= DISCARD;
        end
        DISCARD: if (imem_rvalid_i) state <= FETCH;
        default: state <= FETCH;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (br_taken_i) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_pc[wr_ptr]    <= req_pc;
      fifo_instr[wr_ptr] <= imem_rdata_i;
    end
  end

  assign instr_valid_o = (count != 2'd0);
  assign instr_o       = instr_valid_o ? fifo_instr[rd_ptr] : NOP_INSTR;
  assign pc_o          = instr_valid_o ? fifo_pc[rd_ptr] : 32'd0;
  assign pc_plus4_o    = pc_o + 32'd4;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: behavioural instruction memory with programmable latency,
// expected-fetch-address model and a scoreboard of delivered {pc, instr}.
module tb_if_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        br_taken_i = 1'b0;
  logic [31:0] new_pc_i = '0;
  logic        stall_i = 1'b0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ready_i = 1'b0;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic        instr_valid_o;
  logic [31:0] instr_o, pc_o, pc_plus4_o;

  if_stage #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
    .clk_i(clk), .rst_i(rst_i), .br_taken_i(br_taken_i), .new_pc_i(new_pc_i),
    .stall_i(stall_i), .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_ready_i(imem_ready_i), .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .instr_valid_o(instr_valid_o), .instr_o(instr_o), .pc_o(pc_o), .pc_plus4_o(pc_plus4_o)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
  typedef struct {
    logic [31:0] new_pc, exp_addr, exp_p4, exp_next;
    int          lat;
    bit          in_wait;
  } vec_t;

  ent_t        q[$];
  logic [31:0] pop_pcs[$];
  vec_t        vecs[4];

  int n_pass = 0, n_total = 0;

  // memory model state
  bit          ready_en = 1'b1, const_mode = 1'b1;
  int          lat = 1;
  bit          pend = 1'b0, pend_stale = 1'b0;
  int          pend_cnt = 0;
  logic [31:0] pend_addr = '0;
  logic [31:0] exp_fetch = RST_PC;
  logic [31:0] last_acc = '0;
  bit          acc_flag = 1'b0;

  // sampled DUT outputs
  logic        s_req, s_valid;
  logic [31:0] s_addr, s_instr, s_pc, s_p4;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return const_mode ? 32'h0050_0093 : (a ^ 32'hC0DE_0000);
  endfunction

  task automatic sample();
    s_req = imem_req_o; s_addr = imem_addr_o; s_valid = instr_valid_o;
    s_instr = instr_o; s_pc = pc_o; s_p4 = pc_plus4_o;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req"},   {31'd0, imem_req_o}, 32'd0);
    chk({tag, "_addr"},  imem_addr_o, RST_PC);
    chk({tag, "_valid"}, {31'd0, instr_valid_o}, 32'd0);
    chk({tag, "_instr"}, instr_o, NOP);
    chk({tag, "_pc"},    pc_o, 32'd0);
    chk({tag, "_p4"},    pc_plus4_o, 32'd4);
  endtask

  // One clock cycle: drive memory side, sample at negedge, update model/scoreboard.
  task automatic step();
    bit acc, fire;
    ent_t e;
    imem_ready_i  = ready_en;
    imem_rvalid_i = pend && (pend_cnt == 0);
    imem_rdata_i  = mem_data(pend_addr);
    @(negedge clk);
    sample();
    acc  = s_req && imem_ready_i;
    fire = imem_rvalid_i;
    acc_flag = acc;
    if (!s_valid) begin
      chk("idle_instr", s_instr, NOP);
      chk("idle_pc", s_pc, 32'd0);
    end else if (!stall_i) begin
      pop_pcs.push_back(s_pc);
      if (q.size() == 0) chk("pop_unexpected", s_pc, 32'hxxxx_xxxx);
      else begin
        e = q.pop_front();
        chk("pop_pc", s_pc, e.pc);
        chk("pop_instr", s_instr, e.instr);
        chk("pop_pc_plus4", s_p4, e.pc + 32'd4);
      end
    end
    if (fire) begin
      if (!pend_stale && !br_taken_i) q.push_back('{pend_addr, mem_data(pend_addr)});
      pend = 1'b0;
    end else if (pend) pend_cnt--;
    if (acc) begin
      if (pend) chk("one_outstanding", 32'd1, 32'd0);
      chk("fetch_addr", s_addr, exp_fetch);
      exp_fetch = exp_fetch + 32'd4;
    end
    if (br_taken_i) begin
      q.delete();
      if (pend) pend_stale = 1'b1;
      exp_fetch = {br_taken_i ? new_pc_i[31:2] : 30'd0, 2'b00};
    end
    if (acc) begin
      pend = 1'b1; pend_addr = s_addr; pend_cnt = lat - 1;
      pend_stale = br_taken_i; last_acc = s_addr;
    end
    @(posedge clk); #1;
  endtask

  task automatic timeout(input string name);
    chk({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    bit ok;
    vecs[0] = '{32'h0000_0103, 32'h0000_0100, 32'h0000_0104, 32'h0000_0104, 3, 1'b1};
    vecs[1] = '{32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0000, 1, 1'b0};
    vecs[2] = '{32'h0000_1001, 32'h0000_1000, 32'h0000_1004, 32'h0000_1004, 2, 1'b1};
    vecs[3] = '{32'h8000_2002, 32'h8000_2000, 32'h8000_2004, 32'h8000_2004, 1, 1'b0};

    // reset values, then first fetch stream with constant data
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    @(posedge clk); #1;
    rst_i = 1'b0;
    step();
    chk("req_after_reset", {31'd0, s_req}, 32'd1);
    chk("addr_after_reset", s_addr, RST_PC);
    ok = 1'b0;
    for (int k = 0; k < 30; k++) begin
      if (pop_pcs.size() >= 3) begin ok = 1'b1; break; end
      step();
    end
    if (!ok) timeout("first_stream");
    else begin
      chk("stream_pc0", pop_pcs[0], 32'd0);
      chk("stream_pc1", pop_pcs[1], 32'd4);
      chk("stream_pc2", pop_pcs[2], 32'd8);
    end

    // stall: buffer fills to two, request drops, head held
    const_mode = 1'b0;
    stall_i = 1'b1;
    repeat (10) step();
    chk("stall_depth", q.size(), 32'd2);
    chk("stall_req", {31'd0, s_req}, 32'd0);
    chk("stall_valid", {31'd0, s_valid}, 32'd1);
    if (q.size() > 0) begin
      chk("stall_head_pc", s_pc, q[0].pc);
      chk("stall_head_instr", s_instr, q[0].instr);
    end
    stall_i = 1'b0;
    repeat (12) step();

    // redirect vectors
    foreach (vecs[i]) begin
      lat = vecs[i].lat;
      ok = 1'b0;
      for (int k = 0; k < 40; k++) begin
        if (vecs[i].in_wait ? (pend && !pend_stale && pend_cnt > 0) : !pend) begin
          ok = 1'b1; break;
        end
        step();
      end
      if (!ok) timeout("redir_setup");
      br_taken_i = 1'b1; new_pc_i = vecs[i].new_pc;
      step();
      br_taken_i = 1'b0; new_pc_i = '0;
      step();
      chk("redir_addr", s_addr, vecs[i].exp_addr);
      chk("redir_discard_req", {31'd0, s_req}, 32'd0);
      chk("redir_flushed", {31'd0, s_valid}, 32'd0);
      ok = 1'b0;
      for (int k = 0; k < 20; k++) begin
        step();
        if (acc_flag && !pend_stale) begin ok = 1'b1; break; end
      end
      if (!ok) timeout("redir_accept");
      chk("redir_first_req", last_acc, vecs[i].exp_addr);
      step();
      chk("redir_next_addr", s_addr, vecs[i].exp_next);
      ok = 1'b0;
      for (int k = 0; k < 20; k++) begin
        if (s_valid) begin ok = 1'b1; break; end
        step();
      end
      if (!ok) timeout("redir_deliver");
      chk("redir_head_pc", s_pc, vecs[i].exp_addr);
      chk("redir_head_p4", s_p4, vecs[i].exp_p4);
      repeat (4) step();
    end

    // redirect coinciding with the response: data dropped, straight back to FETCH
    lat = 2;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (pend && !pend_stale && pend_cnt == 0) begin ok = 1'b1; break; end
      step();
    end
    if (!ok) timeout("same_cycle_setup");
    br_taken_i = 1'b1; new_pc_i = 32'h3000_0007;
    step();
    br_taken_i = 1'b0; new_pc_i = '0;
    step();
    chk("same_cycle_addr", s_addr, 32'h3000_0004);
    chk("same_cycle_req", {31'd0, s_req}, 32'd1);
    chk("same_cycle_valid", {31'd0, s_valid}, 32'd0);
    repeat (6) step();

    // asynchronous reset with a request outstanding
    lat = 3;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (pend && !pend_stale) begin ok = 1'b1; break; end
      step();
    end
    if (!ok) timeout("async_rst_setup");
    #2;
    imem_rvalid_i = 1'b0;
    rst_i = 1'b1;
    #1;
    chk_reset_outputs("async_rst");
    q.delete();
    pend_stale = 1'b1;
    exp_fetch = RST_PC;
    @(posedge clk); @(posedge clk); #1;
    rst_i = 1'b0;
    ready_en = 1'b0;
    step();
    chk("rst_release_req", {31'd0, s_req}, 32'd1);
    chk("rst_release_addr", s_addr, RST_PC);
    ok = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (!pend) begin ok = 1'b1; break; end
      step();
    end
    if (!ok) timeout("stale_drop");
    ready_en = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (acc_flag) begin ok = 1'b1; break; end
    end
    if (!ok) timeout("rst_refetch");
    chk("rst_refetch_addr", last_acc, RST_PC);
    repeat (10) step();

    // drain
    ready_en = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 30; k++) begin
      if (!pend && q.size() == 0) begin ok = 1'b1; break; end
      step();
    end
    if (!ok) timeout("drain");
    step();
    chk("drained_valid", {31'd0, s_valid}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
